// File: rtl/def.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : def                                                          |
// | Description : Shared pipeline types. 'instructions' is the decoded one-hot |
// |               opcode vector; 'regvpair' carries the two source operands.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package def;

  typedef struct packed {
    logic add;
    logic addi;
    logic lb;
    logic lh;
    logic lw;
    logic lbu;
    logic lhu;
    logic sb;
    logic sh;
    logic sw;
  } instructions;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
  } regvpair;

endpackage
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_access                                                   |
// | Description : Memory stage. Turns a decoded load/store into one or two     |
// |               word-aligned bus transactions (two when a misaligned half or |
// |               word crosses a word boundary), aligns store data into byte   |
// |               lanes and extracts/extends load data. Non-memory ops pass    |
// |               alu_result through with a one-cycle done pulse.              |
// | Ports       : clk, rst (async, active-high)                                |
// |               enabled/instr/register/alu_result : start request from ALU   |
// |               completed/result/fault/fault_addr : done pulse and outcome   |
// |               mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb : bus request    |
// |               mem_ready/mem_rdata : bus response                           |
// | Config      : MISALIGN_TRAP_EN - when defined, misaligned half/word        |
// |               accesses raise fault instead of being split.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_access
  import def::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enabled,
  input  instructions instr,
  input  regvpair     register,
  input  logic [31:0] alu_result,
  output logic        completed,
  output logic [31:0] result,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] c_SZ_BYTE = 2'd0;
  localparam logic [1:0] c_SZ_HALF = 2'd1;
  localparam logic [1:0] c_SZ_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, REQ2, DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_mem_req, w_mem_req_nxt;
  logic        r_mem_we, w_mem_we_nxt;
  logic [31:0] r_mem_addr, w_mem_addr_nxt;
  logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [3:0]  r_mem_wstrb, w_mem_wstrb_nxt;
  logic        r_completed, w_completed_nxt;
  logic [31:0] r_result, w_result_nxt;
  logic        r_fault, w_fault_nxt;
  logic [31:0] r_fault_addr, w_fault_addr_nxt;
  // Access context latched at start
  logic [1:0]  r_off, w_off_nxt;
  logic [1:0]  r_size, w_size_nxt;
  logic        r_sign, w_sign_nxt;
  logic        r_store, w_store_nxt;
  logic        r_cross, w_cross_nxt;
  logic [31:0] r_wdata_hi, w_wdata_hi_nxt;
  logic [3:0]  r_wstrb_hi, w_wstrb_hi_nxt;
  logic [31:0] r_rdata_lo, w_rdata_lo_nxt;

  logic        w_is_load, w_is_store, w_is_mem, w_misaligned, w_trap;
  logic [1:0]  w_size;
  logic [3:0]  w_mask4;
  logic [7:0]  w_m8;
  logic [63:0] w_d64;
  logic        w_unused;

  assign w_is_load  = instr.lb | instr.lh | instr.lw | instr.lbu | instr.lhu;
  assign w_is_store = instr.sb | instr.sh | instr.sw;
  assign w_is_mem   = w_is_load | w_is_store;

  always_comb begin
    w_size = c_SZ_WORD;
    if (instr.lb | instr.lbu | instr.sb)      w_size = c_SZ_BYTE;
    else if (instr.lh | instr.lhu | instr.sh) w_size = c_SZ_HALF;
  end

  assign w_mask4 = (w_size == c_SZ_BYTE) ? 4'b0001 :
                   (w_size == c_SZ_HALF) ? 4'b0011 : 4'b1111;
  // Lane mask and data over an 8-byte window: the upper nibble/word is the
  // portion spilling into the next word, non-zero only for crossing accesses.
  assign w_m8  = {4'b0000, w_mask4} << alu_result[1:0];
  assign w_d64 = {32'h0, register.rs2} << {alu_result[1:0], 3'b000};

  assign w_misaligned = ((w_size == c_SZ_HALF) & alu_result[0]) |
                        ((w_size == c_SZ_WORD) & (|alu_result[1:0]));

`ifdef MISALIGN_TRAP_EN
  assign w_trap = w_is_mem & w_misaligned;
`else
  assign w_trap = 1'b0;
`endif

  assign w_unused = ^{register.rs1, instr.add, instr.addi, w_misaligned};

  // Shift the (possibly two-word) read window down to the access start and extend
  function automatic logic [31:0] load_extend(input logic [63:0] i_rd, input logic [1:0] i_off,
                                              input logic [1:0] i_size, input logic i_sign);
    logic [31:0] sh;
    logic [31:0] val;
    sh = 32'(i_rd >> {i_off, 3'b000});
    case (i_size)
      c_SZ_BYTE: val = {{24{i_sign & sh[7]}}, sh[7:0]};
      c_SZ_HALF: val = {{16{i_sign & sh[15]}}, sh[15:0]};
      default:   val = sh;
    endcase
    return val;
  endfunction

  always_comb begin
    w_state_nxt      = r_state;
    w_mem_req_nxt    = r_mem_req;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_mem_wstrb_nxt  = r_mem_wstrb;
    w_completed_nxt  = 1'b0;
    w_result_nxt     = r_result;
    w_fault_nxt      = r_fault;
    w_fault_addr_nxt = r_fault_addr;
    w_off_nxt        = r_off;
    w_size_nxt       = r_size;
    w_sign_nxt       = r_sign;
    w_store_nxt      = r_store;
    w_cross_nxt      = r_cross;
    w_wdata_hi_nxt   = r_wdata_hi;
    w_wstrb_hi_nxt   = r_wstrb_hi;
    w_rdata_lo_nxt   = r_rdata_lo;
    case (r_state)
      IDLE: begin
        if (enabled) begin
          if (w_trap) begin
            w_state_nxt      = DONE;
            w_completed_nxt  = 1'b1;
            w_fault_nxt      = 1'b1;
            w_fault_addr_nxt = alu_result;
            w_result_nxt     = '0;
          end else if (w_is_mem) begin
            w_state_nxt     = REQ;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = w_is_store;
            w_mem_addr_nxt  = {alu_result[31:2], 2'b00};
            w_mem_wdata_nxt = w_is_store ? w_d64[31:0] : 32'h0;
            w_mem_wstrb_nxt = w_is_store ? w_m8[3:0] : 4'b0000;
            w_off_nxt       = alu_result[1:0];
            w_size_nxt      = w_size;
            w_sign_nxt      = instr.lb | instr.lh;
            w_store_nxt     = w_is_store;
            w_cross_nxt     = |w_m8[7:4];
            w_wdata_hi_nxt  = w_d64[63:32];
            w_wstrb_hi_nxt  = w_is_store ? w_m8[7:4] : 4'b0000;
          end else begin
            w_state_nxt     = DONE;
            w_completed_nxt = 1'b1;
            w_result_nxt    = alu_result;
          end
        end
      end
      REQ: begin
        if (r_mem_req && mem_ready) begin
          w_mem_req_nxt = 1'b0;
          if (r_cross) begin
            w_state_nxt     = REQ2;
            w_mem_addr_nxt  = r_mem_addr + 32'd4;
            w_mem_wdata_nxt = r_wdata_hi;
            w_mem_wstrb_nxt = r_wstrb_hi;
            w_rdata_lo_nxt  = mem_rdata;
          end else begin
            w_state_nxt     = DONE;
            w_completed_nxt = 1'b1;
            w_result_nxt    = r_store ? 32'h0 : load_extend({32'h0, mem_rdata}, r_off, r_size, r_sign);
          end
        end
      end
      REQ2: begin
        // Enter with mem_req low for one cycle to separate the two transactions
        if (!r_mem_req) begin
          w_mem_req_nxt = 1'b1;
        end else if (mem_ready) begin
          w_mem_req_nxt   = 1'b0;
          w_state_nxt     = DONE;
          w_completed_nxt = 1'b1;
          w_result_nxt    = r_store ? 32'h0 : load_extend({mem_rdata, r_rdata_lo}, r_off, r_size, r_sign);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_fault_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wstrb  <= '0;
      r_completed  <= 1'b0;
      r_result     <= '0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
      r_off        <= '0;
      r_size       <= '0;
      r_sign       <= 1'b0;
      r_store      <= 1'b0;
      r_cross      <= 1'b0;
      r_wdata_hi   <= '0;
      r_wstrb_hi   <= '0;
      r_rdata_lo   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_mem_wstrb  <= w_mem_wstrb_nxt;
      r_completed  <= w_completed_nxt;
      r_result     <= w_result_nxt;
      r_fault      <= w_fault_nxt;
      r_fault_addr <= w_fault_addr_nxt;
      r_off        <= w_off_nxt;
      r_size       <= w_size_nxt;
      r_sign       <= w_sign_nxt;
      r_store      <= w_store_nxt;
      r_cross      <= w_cross_nxt;
      r_wdata_hi   <= w_wdata_hi_nxt;
      r_wstrb_hi   <= w_wstrb_hi_nxt;
      r_rdata_lo   <= w_rdata_lo_nxt;
    end
  end

  assign completed  = r_completed;
  assign result     = r_result;
  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_wstrb  = r_mem_wstrb;

endmodule
`default_nettype wire
